// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// -----------------------------------------------------------------------------
// Time-multiplexed scan controller for a bank of common-anode 7-segment digits
// that share one external BCD-to-7-segment decoder. Each digit gets a blanking
// gap (all digits off) followed by a lit interval. The decoder input changes
// only at the start of a gap, so its output has settled before any digit is
// enabled (anti-ghosting). Input digits, mask and leading-zero mode are
// captured once per frame so a frame never mixes old and new values.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   en           scan enable, 0 = display dark
//   digits_bcd   packed BCD digits, digit i at [4i+3:4i], digit 0 = LSD
//   blank_mask   1 = force digit i dark
//   lz_suppress  1 = blank leading zeros (digit 0 is never suppressed)
//   bcd_out      code to the shared decoder, 4'hF = blank
//   seg_in       active-low segments from the shared decoder
//   seg_out      active-low segments to the pins
//   digit_sel_n  active-low digit enables, at most one low
//   frame_start  one-cycle pulse when a new frame snapshot is taken
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_start
);

  localparam int MAX_CNT = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]       BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_mask_q;
  logic                    snap_lz_q;
  logic [3:0]              bcd_out_q;
  logic [NUM_DIGITS-1:0]   digit_sel_n_q;
  logic                    frame_start_q;

  logic                    last_digit;
  logic                    show_done;
  logic                    take_snap;
  logic [IDX_W-1:0]        idx_d;
  logic [3:0]              bcd_d;
  logic [NUM_DIGITS-1:0]   sel_lit_n;

  // Code source: when a snapshot is being taken this cycle, the first digit of
  // the new frame must already be coded from the incoming values.
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_mask;
  logic                    src_lz;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [3:0]              code_vec [NUM_DIGITS];

  always_comb begin
    last_digit = (idx_q == IDX_LAST);
    show_done  = (state_q == SHOW) && (cnt_q == SHOW_LAST);
    take_snap  = en && ((state_q == IDLE) || (show_done && last_digit));
    idx_d      = ((state_q == IDLE) || last_digit) ? '0 : idx_q + IDX_W'(1);
    src_digits = take_snap ? digits_bcd  : snap_digits_q;
    src_mask   = take_snap ? blank_mask  : snap_mask_q;
    src_lz     = take_snap ? lz_suppress : snap_lz_q;
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_code
    // Digit gi is a leading zero when it and every more significant digit is 0.
    assign upper_zero[gi] = ~|src_digits[4*NUM_DIGITS-1:4*gi];
    assign code_vec[gi] =
        src_mask[gi]                            ? BLANK_CODE :
        (src_lz && (gi != 0) && upper_zero[gi]) ? BLANK_CODE :
                                                  src_digits[4*gi +: 4];
  end

  assign bcd_d     = code_vec[idx_d];
  assign sel_lit_n = ~(NUM_DIGITS'(1) << idx_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      snap_digits_q <= '0;
      snap_mask_q   <= '0;
      snap_lz_q     <= 1'b0;
      bcd_out_q     <= BLANK_CODE;
      digit_sel_n_q <= '1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (take_snap) begin
        snap_digits_q <= digits_bcd;
        snap_mask_q   <= blank_mask;
        snap_lz_q     <= lz_suppress;
        frame_start_q <= 1'b1;
      end
      if (!en) begin
        // Disable from any state: go dark and restart at digit 0 later.
        state_q       <= IDLE;
        idx_q         <= '0;
        cnt_q         <= '0;
        bcd_out_q     <= BLANK_CODE;
        digit_sel_n_q <= '1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q       <= BLANK;
            idx_q         <= idx_d;
            cnt_q         <= '0;
            bcd_out_q     <= bcd_d;
            digit_sel_n_q <= '1;
          end
          BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              state_q       <= SHOW;
              cnt_q         <= '0;
              digit_sel_n_q <= sel_lit_n;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          SHOW: begin
            if (show_done) begin
              // Decoder input only moves here, while every digit is off.
              state_q       <= BLANK;
              cnt_q         <= '0;
              idx_q         <= idx_d;
              bcd_out_q     <= bcd_d;
              digit_sel_n_q <= '1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            bcd_out_q     <= BLANK_CODE;
            digit_sel_n_q <= '1;
          end
        endcase
      end
    end
  end

  assign bcd_out     = bcd_out_q;
  assign digit_sel_n = digit_sel_n_q;
  assign frame_start = frame_start_q;
  assign seg_out     = (state_q == SHOW) ? seg_in : 7'h7F;

endmodule
